// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
//   Receive side of a 4-bit Gray-coded position/counter link. The incoming
//   Gray word is resynchronised into clk, every step is checked to change
//   exactly one bit, legal steps are decoded to binary with a direction
//   flag, and illegal multi-bit jumps are flagged, counted and force the
//   tracker back into acquisition.
//
//   Parameters
//     SYNC_STAGES : synchroniser depth (legal 2..4)
//     ERR_CNT_W   : width of the saturating error counter
//   Ports
//     clk       in   single clock, rising edge
//     rst_n     in   synchronous reset, active low
//     gray_in   in   [3:0] Gray word, may be asynchronous to clk
//     en        in   tracking enable; low freezes decoding and drops lock
//     bin_out   out  [3:0] last accepted value, binary
//     bin_valid out  one-cycle strobe when bin_out is loaded
//     dir       out  direction of last accepted step (1 = up), sticky
//     locked    out  high while tracking
//     step_err  out  one-cycle strobe on an illegal multi-bit change
//     err_cnt   out  [ERR_CNT_W-1:0] saturating count of step_err events
module gray_sync_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           gray_in,
  input  logic                 en,
  output logic [3:0]           bin_out,
  output logic                 bin_valid,
  output logic                 dir,
  output logic                 locked,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]   sync_q;
  logic [3:0]                    g_s;
  logic [3:0]                    g_prev, g_prev_d;
  logic [3:0]                    bin_d;
  logic                          vld_d, dir_d, err_d;
  logic [ERR_CNT_W-1:0]          cnt_d;

  logic [3:0]                    diff;
  logic [3:0]                    dec;
  logic                          one_bit, multi_bit;

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Synchroniser chain; runs every cycle independent of en so the tracker
  // always sees a fresh sample when it is re-enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s  = sync_q[SYNC_STAGES-1];
  assign diff = g_s ^ g_prev;
  assign dec  = gray2bin(g_s);
  // x & (x-1) clears the lowest set bit; zero afterwards means a single bit.
  assign one_bit   = (diff != 4'd0) && ((diff & (diff - 4'd1)) == 4'd0);
  assign multi_bit = (diff != 4'd0) && !one_bit;

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    g_prev_d = g_prev;
    bin_d    = bin_out;
    vld_d    = 1'b0;
    dir_d    = dir;
    err_d    = 1'b0;
    cnt_d    = err_cnt;
    case (state_q)
      ACQ: begin
        if (en) begin
          if (g_s == g_prev) begin
            // Two matching samples in a row: trust the word and lock.
            bin_d   = dec;
            vld_d   = 1'b1;
            state_d = TRACK;
          end else begin
            g_prev_d = g_s;
          end
        end
      end
      TRACK: begin
        if (!en) begin
          // A simultaneous illegal jump is deliberately not reported here.
          state_d = ACQ;
        end else if (one_bit) begin
          g_prev_d = g_s;
          bin_d    = dec;
          vld_d    = 1'b1;
          // 4-bit add wraps, so 15 -> 0 reads as up and 0 -> 15 as down.
          dir_d    = (dec == bin_out + 4'd1);
        end else if (multi_bit) begin
          err_d    = 1'b1;
          if (!(&err_cnt)) cnt_d = err_cnt + ERR_CNT_W'(1);
          g_prev_d = g_s;
          state_d  = ACQ;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACQ;
      g_prev    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      dir       <= 1'b0;
      locked    <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      g_prev    <= g_prev_d;
      bin_out   <= bin_d;
      bin_valid <= vld_d;
      dir       <= dir_d;
      locked    <= (state_d == TRACK);
      step_err  <= err_d;
      err_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
module tb_gray_sync_decoder;
  localparam int SS = 2;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    gray_in;
  logic          en;
  logic [3:0]    bin_out;
  logic          bin_valid;
  logic          dir;
  logic          locked;
  logic          step_err;
  logic [CW-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  gray_sync_decoder #(.SYNC_STAGES(SS), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .en(en),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir(dir), .locked(locked),
    .step_err(step_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: a delay line of raw samples plus the tracking
  // rules written directly in terms of values (mod-16 arithmetic, bit counts).
  logic [3:0]    m_line [SS];
  logic          m_trk;
  logic [3:0]    m_gp, m_bin;
  logic          m_vld, m_dir, m_lk, m_err;
  logic [CW-1:0] m_cnt;

  wire [CW+7:0] dut_v = {bin_out, bin_valid, dir, locked, step_err, err_cnt};
  wire [CW+7:0] mdl_v = {m_bin, m_vld, m_dir, m_lk, m_err, m_cnt};

  function automatic logic [3:0] b2g(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic int g2b(input logic [3:0] g);
    for (int b = 0; b < 16; b++) if (b2g(b) == g) return b;
    return 0;
  endfunction

  // Apply the rules to the inputs that the coming edge will sample.
  task automatic model_step();
    logic [3:0] g;
    int nb;
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) m_line[i] = 4'd0;
      m_trk = 0; m_gp = 0; m_bin = 0; m_vld = 0; m_dir = 0; m_lk = 0; m_err = 0; m_cnt = 0;
      return;
    end
    g = m_line[SS-1];
    m_vld = 0; m_err = 0;
    if (!en) m_trk = 0;
    else if (!m_trk) begin
      if (g == m_gp) begin m_bin = 4'(g2b(g)); m_vld = 1; m_trk = 1; end
      else m_gp = g;
    end else if ($countones(g ^ m_gp) == 1) begin
      nb = g2b(g);
      m_dir = (nb == (int'(m_bin) + 1) % 16);
      m_bin = 4'(nb); m_gp = g; m_vld = 1;
    end else if ($countones(g ^ m_gp) > 1) begin
      m_err = 1;
      if (int'(m_cnt) < (1 << CW) - 1) m_cnt = m_cnt + 1'b1;
      m_gp = g; m_trk = 0;
    end
    m_lk = m_trk;
    for (int i = SS - 1; i > 0; i--) m_line[i] = m_line[i-1];
    m_line[0] = gray_in;
  endtask

  task automatic cyc(input logic [3:0] g, input logic e);
    gray_in = g;
    en = e;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(4'($urandom_range(0, 15)), 1'b1);
      checks++;
      if (dut_v !== '0) begin
        errors++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, dut_v);
      end
    end
    // gray_in zero for long enough that the chain holds zero either way
    for (int i = 0; i < SS; i++) cyc(4'd0, 1'b1);
    rst_n = 1'b1;
    cyc(4'd0, 1'b1);
    checks++;
    if ({locked, bin_valid, bin_out, step_err} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL initial_lock got lk=%b vld=%b bin=%0d err=%b exp lk=1 vld=1 bin=0 err=0",
               locked, bin_valid, bin_out, step_err);
    end
    cyc(4'd0, 1'b1);
    checks++;
    if (bin_valid !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL initial_pulse_width got vld=%b lk=%b exp vld=0 lk=1", bin_valid, locked);
    end
  endtask

  task automatic test_up_wrap();
    int v;
    for (int k = 1; k <= 18; k++) begin
      v = (k <= 16) ? k % 16 : 0;
      cyc(b2g(v), 1'b1);
      if (k >= 3) begin
        checks++;
        if ({bin_out, bin_valid, dir, locked} !== {4'((k - 2) % 16), 3'b111}) begin
          errors++;
          $display("FAIL up_wrap k=%0d got bin=%0d vld=%b dir=%b lk=%b exp bin=%0d vld=1 dir=1 lk=1",
                   k, bin_out, bin_valid, dir, locked, (k - 2) % 16);
        end
      end
    end
  endtask

  task automatic test_down();
    logic [3:0] gs [6]   = '{4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    logic [3:0] bexp [6] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd15, 4'd0};
    logic       dexp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 3; i++) cyc(gs[s], 1'b1);
      checks++;
      if ({bin_out, dir, bin_valid} !== {bexp[s], dexp[s], 1'b1}) begin
        errors++;
        $display("FAIL down_step s=%0d got bin=%0d dir=%b vld=%b exp bin=%0d dir=%b vld=1",
                 s, bin_out, dir, bin_valid, bexp[s], dexp[s]);
      end
      cyc(gs[s], 1'b1);
      checks++;
      if (bin_valid !== 1'b0 || bin_out !== bexp[s]) begin
        errors++;
        $display("FAIL down_hold s=%0d got vld=%b bin=%0d exp vld=0 bin=%0d", s, bin_valid, bin_out, bexp[s]);
      end
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) cyc(4'b0011, 1'b1);
    checks++;
    if ({step_err, err_cnt, locked, bin_out, bin_valid} !== {1'b1, 8'd1, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL illegal_jump got err=%b cnt=%0d lk=%b bin=%0d vld=%b exp err=1 cnt=1 lk=0 bin=0 vld=0",
               step_err, err_cnt, locked, bin_out, bin_valid);
    end
    cyc(4'b0011, 1'b1);
    checks++;
    if ({locked, bin_out, bin_valid, step_err} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_relock got lk=%b bin=%0d vld=%b err=%b exp lk=1 bin=2 vld=1 err=0",
               locked, bin_out, bin_valid, step_err);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int p = 0; p < 150; p++) begin
      for (int h = 0; h < 4; h++) begin
        cyc((h < 2) ? 4'b0000 : 4'b0011, 1'b1);
        pulses += int'(step_err);
        checks++;
        if (dut_v !== mdl_v) begin
          errors++; $display("FAIL sat_model p=%0d h=%0d got=%h exp=%h", p, h, dut_v, mdl_v);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0011, 1'b1);
      pulses += int'(step_err);
    end
    checks++;
    if (pulses != 300) begin
      errors++; $display("FAIL sat_pulses got=%0d exp=300", pulses);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_count got=%0d exp=255", err_cnt);
    end
  endtask

  task automatic test_reset_enable();
    rst_n = 1'b0;
    cyc(4'b0000, 1'b1);
    checks++;
    if (dut_v !== '0) begin
      errors++; $display("FAIL midop_reset got=%h exp=0", dut_v);
    end
    rst_n = 1'b1;
    cyc(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0001, 1'b1);
    checks++;
    if ({locked, bin_out, err_cnt} !== {1'b1, 4'd1, 8'd0}) begin
      errors++; $display("FAIL midop_track got lk=%b bin=%0d cnt=%0d exp lk=1 bin=1 cnt=0", locked, bin_out, err_cnt);
    end
    cyc(4'b0001, 1'b0);
    checks++;
    if ({locked, bin_valid, step_err, bin_out} !== {3'b000, 4'd1}) begin
      errors++;
      $display("FAIL en_drop got lk=%b vld=%b err=%b bin=%0d exp lk=0 vld=0 err=0 bin=1",
               locked, bin_valid, step_err, bin_out);
    end
    cyc(4'b0001, 1'b1);
    checks++;
    if ({locked, bin_valid, bin_out} !== {2'b11, 4'd1}) begin
      errors++; $display("FAIL en_relock got lk=%b vld=%b bin=%0d exp lk=1 vld=1 bin=1", locked, bin_valid, bin_out);
    end
    // illegal jump reaches the tracker in the same cycle en goes low
    cyc(4'b0111, 1'b1);
    cyc(4'b0111, 1'b1);
    cyc(4'b0111, 1'b0);
    checks++;
    if ({step_err, err_cnt, locked} !== {1'b0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL en_low_jump got err=%b cnt=%0d lk=%b exp err=0 cnt=0 lk=0", step_err, err_cnt, locked);
    end
    cyc(4'b0111, 1'b1);
    cyc(4'b0111, 1'b1);
    checks++;
    if ({locked, bin_valid, bin_out, dir} !== {2'b11, 4'd5, 1'b1}) begin
      errors++;
      $display("FAIL en_low_reacq got lk=%b vld=%b bin=%0d dir=%b exp lk=1 vld=1 bin=5 dir=1",
               locked, bin_valid, bin_out, dir);
    end
  endtask

  task automatic test_random();
    logic [3:0] g = gray_in;
    int r;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75) g[$urandom_range(0, 3)] ^= 1'b1;
      else if (r < 88) g = 4'($urandom_range(0, 15));
      cyc(g, ($urandom_range(0, 99) < 92));
      checks++;
      if (dut_v !== mdl_v) begin
        errors++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_v, mdl_v);
      end
      checks++;
      if (bin_valid && step_err) begin
        errors++; $display("FAIL random_excl i=%0d got vld=1 err=1 exp not both", i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    gray_in = 4'd0;
    test_reset();
    test_up_wrap();
    test_down();
    test_illegal();
    test_saturation();
    test_reset_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
# gray_sync_decoder

Receive-side stage for the 4-bit Gray code produced by the binary-to-Gray encoder. It resynchronises the Gray word into the local clock domain and checks that every step changes exactly one bit. Valid steps are decoded back to binary with a valid strobe and a direction flag. Illegal multi-bit jumps are flagged, counted, and force re-acquisition.

## Interface

Parameters:
- SYNC_STAGES, default 2: depth of the input synchroniser chain; legal range 2..4.
- ERR_CNT_W, default 8: width of the saturating error counter.

Ports:
- clk, input, 1: single clock; every register samples on its rising edge.
- rst_n, input, 1: synchronous reset, active-low, sampled on the rising edge of clk.
- gray_in, input, 4: Gray word; may be driven from another clock domain.
- en, input, 1: tracking enable. Low freezes decoding and drops lock.
- bin_out, output, 4: last accepted value, decoded to binary.
- bin_valid, output, 1: one-cycle pulse when bin_out is loaded.
- dir, output, 1: direction of the last accepted step. 1 = up (+1 mod 16), 0 = down; holds its value between steps.
- locked, output, 1: 1 while in TRACK.
- step_err, output, 1: one-cycle pulse on an illegal multi-bit change.
- err_cnt, output, ERR_CNT_W: saturating count of step_err events.

## Operation

- **Synchroniser.** Chain s[0..SYNC_STAGES-1] of 4-bit registers, shifting on every clock regardless of en. Its last stage is g_s.
- **Previous-value register.** g_prev holds the last accepted Gray word.
- **Decode.** b[3] = g[3]; b[i] = b[i+1] ^ g[i] for i = 2..0.
- **State machine.** States are ACQ and TRACK; reset state is ACQ.
  - ACQ, en=1, g_s == g_prev: load bin_out = decode(g_s), pulse bin_valid, leave dir unchanged, go to TRACK.
  - ACQ, en=1, g_s != g_prev: g_prev <= g_s, stay in ACQ.
  - ACQ, en=0: hold all registers except the synchroniser.
  - TRACK, en=0: go to ACQ; no pulses.
  - TRACK, en=1, diff = g_s ^ g_prev:
    - Zero bits set: no action.
    - Exactly one bit set: g_prev <= g_s, bin_out <= decode(g_s), pulse bin_valid. dir <= 1 if decode(g_s) == bin_out + 1 mod 16, else 0. Wrap 15->0 counts as up; 0->15 counts as down.
    - Two or more bits set: pulse step_err, increment err_cnt (saturating at all-ones), g_prev <= g_s, hold bin_out, go to ACQ.
- **Simultaneous events.**
  - rst_n low overrides everything.
  - en low in the same cycle as a multi-bit diff: no step_err and no count; go to ACQ.
  - Saturated err_cnt still produces step_err pulses.
- **locked** = (state == TRACK), registered.

## Timing

- **Reset values.** While rst_n is low at an edge, the following load 0: the synchroniser, g_prev, bin_out, bin_valid, dir, locked, step_err and err_cnt. The state loads ACQ.
- **Latency.** gray_in stable before edge E is visible as g_s after edge E+SYNC_STAGES-1. bin_out, bin_valid, dir and step_err update after edge E+SYNC_STAGES (2 edges with the default).
- **Initial lock.** After reset with gray_in = 0 and en = 1, lock occurs at the first edge with en high, since g_s == g_prev == 0.
- **Re-acquisition.** Lock returns one edge after g_s is seen equal to g_prev, i.e. the Gray word is stable for two consecutive g_s samples.
- **Pulse width.** bin_valid and step_err are exactly one cycle wide and never asserted together.
- **Throughput.** One step per clock is accepted when gray_in changes at most once per clock.

## Test plan

- **Reset and initial lock.** Reset, then en=1, gray_in=0000 -> locked=1 and bin_valid pulse with bin_out=0 after the first enabled edge. All outputs are 0 during reset.
- **Up count with wrap.** Drive gray 0000,0001,0011,0010,0110,...,1000,0000, one per clock -> bin_out steps 0..15 then 0. bin_valid fires every cycle, dir=1 throughout including the wrap, and each result appears 2 edges after its input.
- **Down step.** From bin 2 (gray 0011), drive 0001 -> bin_out=1, dir=0. Drive 0000 then 1000 -> bin_out=0 then 15, dir=0.
- **Illegal jump.** From gray 0000, drive 0011 -> step_err pulse, err_cnt=1, locked=0, bin_out held at 0. Holding 0011 gives locked=1, bin_out=2, bin_valid pulse one edge later.
- **Counter saturation.** Force 300 illegal jumps -> err_cnt stops at 255 and step_err still pulses on every one.
- **Reset and enable mid-operation.** rst_n low mid-TRACK -> all outputs 0 at the next edge. en=0 during TRACK -> locked=0 next edge with no pulses. en=1 with gray_in stable -> relock in 1 edge.
